// File: rtl/movegen_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : movegen_sequencer
// Purpose  : Runs one move-generation pass over the 64-square mesh. The pass
//            clears the mesh, waits for moves to propagate, scans the squares
//            in order and streams each set direction flag out as a
//            (square, direction) record over a valid/ready handshake.
// Ports    : clk, rst (async, active-high)
//            start, engine_color      -> pass request and side to move
//            color_latched, mesh_clear -> mesh control
//            scan_addr, scan_hits      -> square read port (combinational hits)
//            move_valid/ready/sq/dir   -> move record stream
//            move_count                -> moves accepted this pass
//            busy, done                -> status
//            abort                     -> only with MOVEGEN_ABORT_EN defined
// Config   : MOVEGEN_ABORT_EN adds the abort input
// Revision : 1.0  initial release
// ============================================================================
module movegen_sequencer #(
  parameter int PROP_CYCLES = 8
) (
`ifdef MOVEGEN_ABORT_EN
  input  logic        abort,
`endif
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        engine_color,
  output logic        color_latched,
  output logic        mesh_clear,
  output logic [5:0]  scan_addr,
  input  logic [15:0] scan_hits,
  output logic        move_valid,
  input  logic        move_ready,
  output logic [5:0]  move_sq,
  output logic [3:0]  move_dir,
  output logic [10:0] move_count,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(PROP_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(PROP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_PROP  = 3'd2,
    S_READ  = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [15:0]   pending;
  logic [3:0]    low_dir;
  logic [15:0]   low_onehot;
  logic          last_bit;
  logic          handshake;
  logic          abort_now;

`ifdef MOVEGEN_ABORT_EN
  assign abort_now = abort && (state != S_IDLE);
`else
  assign abort_now = 1'b0;
`endif

  // Priority pick of the lowest pending direction; records leave in
  // ascending bit order.
  always_comb begin
    low_dir = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pending[i]) low_dir = 4'(i);
    end
  end

  assign low_onehot = 16'(1) << low_dir;
  assign last_bit   = (pending & ~low_onehot) == 16'd0;
  assign handshake  = (state == S_EMIT) && move_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_CLEAR;
      S_CLEAR: if (cnt == LAST_CNT) state_n = S_PROP;
      S_PROP:  if (cnt == LAST_CNT) state_n = S_READ;
      S_READ: begin
        if (scan_hits != 16'd0)    state_n = S_EMIT;
        else if (scan_addr == 6'd63) state_n = S_DONE;
      end
      S_EMIT: begin
        if (handshake && last_bit)
          state_n = (scan_addr == 6'd63) ? S_DONE : S_READ;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort_now) state_n = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_latched <= 1'b0;
      move_count    <= 11'd0;
      scan_addr     <= 6'd0;
      cnt           <= '0;
      pending       <= 16'd0;
    end else if (abort_now) begin
      // Partial count is kept for the engine; the record in flight is dropped.
      pending <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            color_latched <= engine_color;
            move_count    <= 11'd0;
            scan_addr     <= 6'd0;
            cnt           <= '0;
          end
        end
        S_CLEAR, S_PROP: begin
          cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        end
        S_READ: begin
          pending <= scan_hits;
          if ((scan_hits == 16'd0) && (scan_addr != 6'd63))
            scan_addr <= scan_addr + 6'd1;
        end
        S_EMIT: begin
          if (handshake) begin
            pending    <= pending & ~low_onehot;
            move_count <= move_count + 11'd1;
            // Address holds while a square still has moves queued.
            if (last_bit && (scan_addr != 6'd63))
              scan_addr <= scan_addr + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mesh_clear = (state == S_CLEAR);
  assign move_valid = (state == S_EMIT);
  assign move_sq    = move_valid ? scan_addr : 6'd0;
  assign move_dir   = move_valid ? low_dir : 4'd0;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_movegen_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_movegen_sequencer
// Purpose  : Bench for movegen_sequencer. A board array stands in for the
//            mesh; the expected record stream and its timing are derived from
//            the board contents plus the number of stalled cycles.
// Revision : 1.0  initial release
// ============================================================================
module tb_movegen_sequencer;
  localparam int P = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        engine_color = 1'b0;
  logic        move_ready = 1'b0;
  logic        abort = 1'b0;
  logic        color_latched, mesh_clear, move_valid, busy, done;
  logic [5:0]  scan_addr, move_sq;
  logic [3:0]  move_dir;
  logic [10:0] move_count;
  logic [15:0] scan_hits;
  logic [15:0] board [64];

  assign scan_hits = board[scan_addr];

  movegen_sequencer #(.PROP_CYCLES(P)) dut (
`ifdef MOVEGEN_ABORT_EN
    .abort(abort),
`endif
    .clk(clk), .rst(rst), .start(start), .engine_color(engine_color),
    .color_latched(color_latched), .mesh_clear(mesh_clear),
    .scan_addr(scan_addr), .scan_hits(scan_hits),
    .move_valid(move_valid), .move_ready(move_ready),
    .move_sq(move_sq), .move_dir(move_dir), .move_count(move_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int sq; int dir; int base; } rec_t;
  rec_t q[$];
  int   seen_sq[$], seen_dir[$];

  int errors = 0, checks = 0;
  int cyc = 0, t0 = 0, c = 0;
  bit go = 0, launching = 0, running = 0, finished = 0, glitch_en = 0, mon_en = 0;
  int rmode = 0, lowcnt = 0, abort_at = 0;
  int S = 0, popped = 0, N = 0, done_cnt = 0, done_c = -1, exp_done_c = 0;
  bit col = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (pass cycle %0d)", nm, act, exp, c);
    end
  endtask

  // Ideal (always-ready) timeline: square s is read at 2P+1+s+(records
  // before it); each record is valid the cycle after, one per cycle.
  task automatic build_model();
    q.delete();
    N = 0;
    for (int sq = 0; sq < 64; sq++)
      for (int d = 0; d < 16; d++)
        if (board[sq][d]) begin
          q.push_back('{sq: sq, dir: d, base: 2*P + 2 + sq + N});
          N++;
        end
  endtask

  // Driver: launches passes, glitches start, aborts, and paces move_ready.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (go) begin
      start = 1'b1; engine_color = col; go = 0; launching = 1;
    end else if (launching) begin
      start = 1'b0; engine_color = ~col; launching = 0; t0 = cyc; running = 1;
    end else if (running && glitch_en)
      start = ((cyc - t0 + 1) == 20) || ((cyc - t0 + 1) == 81);
    else
      start = 1'b0;
    abort = running && (abort_at > 0) && ((cyc - t0 + 1) == abort_at);
    case (rmode)
      0: move_ready = 1'b1;
      1: move_ready = ($urandom_range(0, 3) != 0);
      2: if (move_valid && lowcnt < 5) begin move_ready = 1'b0; lowcnt++; end
         else move_ready = 1'b1;
      default: move_ready = 1'b0;
    endcase
  end

  // Compare process: every cycle of a pass against the model.
  always @(negedge clk) begin
    if (running && mon_en) begin
      bit ev;
      c = cyc - t0 + 1;
      exp_done_c = 2*P + 65 + N + S;
      ev = (q.size() > 0) && (q[0].base + S == c);
      chk("move_valid", int'(move_valid), int'(ev));
      if (ev) begin
        chk("move_sq", int'(move_sq), q[0].sq);
        chk("move_dir", int'(move_dir), q[0].dir);
        chk("scan_addr", int'(scan_addr), q[0].sq);
      end
      chk("done", int'(done), int'(c == exp_done_c));
      chk("busy", int'(busy), int'(c <= exp_done_c));
      chk("mesh_clear", int'(mesh_clear), int'(c <= P));
      chk("move_count", int'(move_count), popped);
      chk("color_latched", int'(color_latched), int'(col));
      if (done) begin done_cnt++; done_c = c; end
      if (move_valid && move_ready) begin
        seen_sq.push_back(int'(move_sq));
        seen_dir.push_back(int'(move_dir));
      end
      if (ev) begin
        if (move_ready) begin void'(q.pop_front()); popped++; end
        else S++;
      end
      if (c >= exp_done_c + 2) begin running = 0; finished = 1; end
    end
  end

  task automatic run_pass(input bit c_in, input int mode, input bit gl);
    build_model();
    col = c_in; rmode = mode; glitch_en = gl; mon_en = 1;
    S = 0; popped = 0; done_cnt = 0; done_c = -1; lowcnt = 0; finished = 0;
    seen_sq.delete(); seen_dir.delete();
    @(negedge clk);
    go = 1;
    for (int k = 0; k < 6000 && !finished; k++) @(negedge clk);
    if (!finished) begin
      checks++; errors++;
      $display("FAIL pass_timeout: got no end expected end within 6000 cycles");
      running = 0;
    end
    mon_en = 0;
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board[i] = 16'h0;
  endtask

  task automatic random_board();
    for (int i = 0; i < 64; i++) begin
      int r;
      r = $urandom_range(0, 5);
      if (r == 0)      board[i] = 16'($urandom);
      else if (r == 1) board[i] = 16'h1 << $urandom_range(0, 15);
      else             board[i] = 16'h0;
    end
  endtask

  initial begin
    clear_board();
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(move_valid), 0);
    chk("rst_clear", int'(mesh_clear), 0);
    chk("rst_count", int'(move_count), 0);
    chk("rst_addr", int'(scan_addr), 0);
    chk("rst_color", int'(color_latched), 0);
    chk("rst_sq_dir", int'({move_sq, move_dir}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Empty board
    run_pass(1'b1, 0, 1'b0);
    chk("empty_done_cycle", done_c, 81);
    chk("empty_done_cnt", done_cnt, 1);
    chk("empty_count", int'(move_count), 0);

    // Square 10 with two hits, continuous ready
    board[10] = 16'h0201;
    run_pass(1'b0, 0, 1'b0);
    chk("sq10_done_cycle", done_c, 83);
    chk("sq10_count", int'(move_count), 2);
    if (seen_sq.size() == 2) begin
      chk("sq10_rec0", seen_sq[0] * 16 + seen_dir[0], 10 * 16 + 0);
      chk("sq10_rec1", seen_sq[1] * 16 + seen_dir[1], 10 * 16 + 9);
    end else chk("sq10_nrec", seen_sq.size(), 2);

    // Same board, first record stalled five cycles
    run_pass(1'b1, 2, 1'b0);
    chk("stall_done_cycle", done_c, 88);
    chk("stall_count", int'(move_count), 2);

    // Start pulses inside a pass are ignored
    clear_board();
    run_pass(1'b0, 0, 1'b1);
    chk("glitch_done_cnt", done_cnt, 1);
    chk("glitch_done_cycle", done_c, 81);

    // Corner squares: full square 0, last square ends in emit
    board[0] = 16'hFFFF; board[63] = 16'h8000;
    run_pass(1'b1, 1, 1'b0);
    chk("corner_count", int'(move_count), 17);

    for (int p = 0; p < 4; p++) begin
      random_board();
      run_pass(1'($urandom_range(0, 1)), 1, 1'b0);
      chk("rand_count", int'(move_count), N);
      chk("rand_done_cnt", done_cnt, 1);
    end

    // Asynchronous reset while square 10 is being emitted
    clear_board();
    board[5] = 16'h0001; board[10] = 16'h0201;
    col = 1'b1; rmode = 2; lowcnt = 0; mon_en = 0;
    @(negedge clk);
    go = 1;
    begin
      int k;
      for (k = 0; k < 300; k++) begin
        @(negedge clk);
        if (move_valid && move_sq == 6'd10) break;
      end
      if (k == 300) chk("rst_test_reach_sq10", 0, 1);
    end
    chk("pre_rst_count", int'(move_count), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", int'(move_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_count", int'(move_count), 0);
    chk("arst_addr", int'(scan_addr), 0);
    chk("arst_color", int'(color_latched), 0);
    running = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_valid", int'(move_valid), 0);

`ifdef MOVEGEN_ABORT_EN
    clear_board();
    board[3] = 16'h0003;
    abort_at = 12; mon_en = 0; rmode = 0; col = 1'b0;
    @(negedge clk);
    go = 1;
    begin
      int dn = 0;
      for (int k = 0; k < 120; k++) begin
        @(negedge clk);
        if (done) dn++;
        if (running && (cyc - t0 + 1) == 12) chk("abort_busy_c12", int'(busy), 1);
        if (running && (cyc - t0 + 1) == 13) begin
          chk("abort_busy_c13", int'(busy), 0);
          chk("abort_clear_c13", int'(mesh_clear), 0);
        end
      end
      chk("abort_no_done", dn, 0);
      chk("abort_count", int'(move_count), 0);
    end
    running = 0; abort_at = 0;
    run_pass(1'b1, 0, 1'b0);
    chk("after_abort_count", int'(move_count), 2);
    chk("after_abort_done_cnt", done_cnt, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
